// File: rtl/vpe_seq_ctrl.sv
// vpe_seq_ctrl -- sequencer for a row of variable-processing elements (VPEs).
//
// Two jobs:
//   * Clause write: a host command selects one word line and one group of four
//     bit lines and drives the SRAM write path for exactly one cycle.
//   * Solve: clear the variable vector, then sweep the VPEs one at a time
//     (PULSE enables VPE k, CAP latches its answer). After each sweep the
//     end-of-chain SATISFY flag is checked. The solve stops on success or when
//     the sweep limit is reached, and then pulses DONE.
//
// Ports
//   CLK, RESET_N         clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY  command handshake (see below)
//   CMD_OP               0 = clause write, 1 = solve, 2/3 = reserved (dropped)
//   CMD_WL, CMD_GRP      write target word line / bit-line group
//   CMD_SIGN, CMD_DATA   write literal sign, {SR, SL, SI} nibbles
//   CMD_ITER             solve sweep limit (0 behaves as 1)
//   WL_SW, WL_SIGN       word-line select and sign (write cycle only)
//   BL_EN, BL_SI/SL/SR   bit-line group enable and data (write cycle only)
//   SRAM_STATE           high during the write cycle
//   V                    broadcast variable vector
//   VUL_EN               per-VPE update enable
//   VAR_STATE, V_PRE     VPE update controls
//   STOCHASTIC_MODE      random-update strobe (stochastic build only)
//   VI_BUS, SATISFY      per-VPE updated values, all-clauses-satisfied flag
//   DONE                 one-cycle solve-complete pulse
//   SOLVED, ITER_CNT     result of the last solve
//   DBG_STATE            current FSM state, for observation only
//
// Build option: define VPE_SEQ_STOCH_EN to build the 16-bit LFSR that drives
// STOCHASTIC_MODE. Without it, STOCHASTIC_MODE is tied low.
//
// Handshake: a command transfers on the rising edge where CMD_VALID and
// CMD_READY are both high. CMD_READY depends only on the controller state
// (high in IDLE only), never on CMD_VALID. The host holds the command stable
// while CMD_VALID is high and CMD_READY is low.

module vpe_seq_ctrl #(
  parameter int NVAR   = 60,
  parameter int ITER_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [5:0]        CMD_WL,
  input  logic [2:0]        CMD_GRP,
  input  logic              CMD_SIGN,
  input  logic [11:0]       CMD_DATA,
  input  logic [ITER_W-1:0] CMD_ITER,
  output logic [NVAR-1:0]   WL_SW,
  output logic              WL_SIGN,
  output logic [7:0]        BL_EN,
  output logic [31:0]       BL_SI,
  output logic [31:0]       BL_SL,
  output logic [31:0]       BL_SR,
  output logic              SRAM_STATE,
  output logic [NVAR-1:0]   V,
  output logic [NVAR-1:0]   VUL_EN,
  output logic              VAR_STATE,
  output logic              V_PRE,
  output logic              STOCHASTIC_MODE,
  input  logic [NVAR-1:0]   VI_BUS,
  input  logic              SATISFY,
  output logic              DONE,
  output logic              SOLVED,
  output logic [ITER_W-1:0] ITER_CNT,
  output logic [2:0]        DBG_STATE
);

  localparam int K_W = $clog2(NVAR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    SEED  = 3'd2,
    PULSE = 3'd3,
    CAP   = 3'd4,
    CHK   = 3'd5,
    FIN   = 3'd6
  } stateT;

  stateT             stateQ, stateD;
  logic [5:0]        wrWl;
  logic [2:0]        wrGrp;
  logic              wrSign;
  logic [11:0]       wrData;
  logic [ITER_W-1:0] iterLimit;
  logic [ITER_W-1:0] iterCnt;
  logic              solved;
  logic [NVAR-1:0]   vReg;
  logic [K_W-1:0]    varIdx;

  logic              cmdFire;
  logic              lastVar;
  logic [ITER_W-1:0] iterInc;
  logic [ITER_W-1:0] effLimit;
  logic              limitHit;

  assign cmdFire  = CMD_VALID && (stateQ == IDLE);
  assign lastVar  = (varIdx == K_W'(NVAR - 1));
  // Sweep counter saturates instead of wrapping to zero.
  assign iterInc  = (iterCnt == '1) ? iterCnt : iterCnt + ITER_W'(1);
  // A zero limit still runs one sweep.
  assign effLimit = (iterLimit == '0) ? ITER_W'(1) : iterLimit;
  assign limitHit = (iterInc >= effLimit);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) stateQ <= IDLE;
    else          stateQ <= stateD;
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (CMD_VALID) begin
          if (CMD_OP == 2'd0)      stateD = WR;
          else if (CMD_OP == 2'd1) stateD = SEED;
        end
      end
      WR:    stateD = IDLE;
      SEED:  stateD = PULSE;
      PULSE: stateD = CAP;
      CAP:   stateD = lastVar ? CHK : PULSE;
      CHK:   stateD = (SATISFY || limitHit) ? FIN : PULSE;
      FIN:   stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wrWl      <= '0;
      wrGrp     <= '0;
      wrSign    <= 1'b0;
      wrData    <= '0;
      iterLimit <= '0;
      iterCnt   <= '0;
      solved    <= 1'b0;
      vReg      <= '0;
      varIdx    <= '0;
    end else begin
      // Write fields are captured at acceptance so the host may move on
      // while the write cycle is in progress.
      if (cmdFire && (CMD_OP == 2'd0)) begin
        wrWl   <= CMD_WL;
        wrGrp  <= CMD_GRP;
        wrSign <= CMD_SIGN;
        wrData <= CMD_DATA;
      end
      if (cmdFire && (CMD_OP == 2'd1)) begin
        iterLimit <= CMD_ITER;
        iterCnt   <= '0;
        solved    <= 1'b0;
      end
      case (stateQ)
        SEED: begin
          vReg   <= '0;
          varIdx <= '0;
        end
        CAP: begin
          vReg[varIdx] <= VI_BUS[varIdx];
          if (!lastVar) varIdx <= varIdx + K_W'(1);
        end
        CHK: begin
          iterCnt <= iterInc;
          varIdx  <= '0;
          if (SATISFY)       solved <= 1'b1;
          else if (limitHit) solved <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode; everything is zero unless the current state drives it.
  always_comb begin
    WL_SW      = '0;
    WL_SIGN    = 1'b0;
    BL_EN      = '0;
    BL_SI      = '0;
    BL_SL      = '0;
    BL_SR      = '0;
    SRAM_STATE = 1'b0;
    VUL_EN     = '0;
    VAR_STATE  = 1'b0;
    case (stateQ)
      WR: begin
        SRAM_STATE = 1'b1;
        // The shift runs off the top of the vector for word lines >= NVAR,
        // so no word line is selected in that case.
        WL_SW      = NVAR'(1) << wrWl;
        WL_SIGN    = wrSign;
        BL_EN      = 8'd1 << wrGrp;
        BL_SI      = 32'(wrData[3:0])  << {wrGrp, 2'b00};
        BL_SL      = 32'(wrData[7:4])  << {wrGrp, 2'b00};
        BL_SR      = 32'(wrData[11:8]) << {wrGrp, 2'b00};
      end
      SEED: begin
        VUL_EN    = '1;
        VAR_STATE = 1'b1;
      end
      PULSE: VUL_EN = NVAR'(1) << varIdx;
      default: ;
    endcase
  end

  assign CMD_READY = (stateQ == IDLE);
  assign DONE      = (stateQ == FIN);
  assign V_PRE     = 1'b0;
  assign V         = vReg;
  assign SOLVED    = solved;
  assign ITER_CNT  = iterCnt;
  assign DBG_STATE = stateQ;

`ifdef VPE_SEQ_STOCH_EN
  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, free-running.
  logic [15:0] lfsr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign STOCHASTIC_MODE = (stateQ == PULSE) && (lfsr[3:0] == 4'd0);
`else
  assign STOCHASTIC_MODE = 1'b0;
`endif

endmodule

// File: tb/tb_vpe_seq_ctrl.sv
// Testbench for vpe_seq_ctrl. Expected values come from a cycle-schedule
// model of the write and solve commands. The model is built from the
// command rules with plain arithmetic; it does not read back the DUT.
module tb_vpe_seq_ctrl;

  localparam int NVAR   = 60;
  localparam int ITER_W = 16;
  localparam int SWEEP  = 2 * NVAR + 1;           // one sweep plus its check cycle
  localparam int WR_W   = NVAR + 1 + 8 + 3 * 32;  // {WL_SW, WL_SIGN, BL_EN, SI, SL, SR}

  // ---------------- clock / reset ----------------
  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic              CMD_VALID, CMD_READY, CMD_SIGN;
  logic [1:0]        CMD_OP;
  logic [5:0]        CMD_WL;
  logic [2:0]        CMD_GRP;
  logic [11:0]       CMD_DATA;
  logic [ITER_W-1:0] CMD_ITER;
  logic [NVAR-1:0]   WL_SW, V, VUL_EN, VI_BUS;
  logic              WL_SIGN, SRAM_STATE, VAR_STATE, V_PRE, STOCHASTIC_MODE;
  logic [7:0]        BL_EN;
  logic [31:0]       BL_SI, BL_SL, BL_SR;
  logic              SATISFY, DONE, SOLVED;
  logic [ITER_W-1:0] ITER_CNT;
  logic [2:0]        DBG_STATE;

  vpe_seq_ctrl #(.NVAR(NVAR), .ITER_W(ITER_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_WL(CMD_WL), .CMD_GRP(CMD_GRP), .CMD_SIGN(CMD_SIGN),
    .CMD_DATA(CMD_DATA), .CMD_ITER(CMD_ITER),
    .WL_SW(WL_SW), .WL_SIGN(WL_SIGN), .BL_EN(BL_EN),
    .BL_SI(BL_SI), .BL_SL(BL_SL), .BL_SR(BL_SR), .SRAM_STATE(SRAM_STATE),
    .V(V), .VUL_EN(VUL_EN), .VAR_STATE(VAR_STATE), .V_PRE(V_PRE),
    .STOCHASTIC_MODE(STOCHASTIC_MODE), .VI_BUS(VI_BUS), .SATISFY(SATISFY),
    .DONE(DONE), .SOLVED(SOLVED), .ITER_CNT(ITER_CNT), .DBG_STATE(DBG_STATE)
  );

  // ---------------- scoreboard state ----------------
  int                tests_run    = 0;
  int                tests_failed = 0;
  logic [WR_W-1:0]   exp_q[$];
  logic              expSolved = 1'b0;
  logic [ITER_W-1:0] expIter   = '0;
  logic [NVAR-1:0]   expV      = '0;

`ifdef VPE_SEQ_STOCH_EN
  // Reference LFSR, from the polynomial x^16+x^14+x^13+x^11+1 and seed ACE1.
  logic [15:0] lfsrModel;
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) lfsrModel <= 16'hACE1;
    else lfsrModel <= (lfsrModel >> 1) |
                      (16'(((lfsrModel ^ (lfsrModel >> 2) ^ (lfsrModel >> 3) ^ (lfsrModel >> 5)) & 16'd1)) << 15);
  end
`endif

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    CMD_VALID = 1'b0; CMD_OP = '0; CMD_WL = '0; CMD_GRP = '0;
    CMD_SIGN = 1'b0; CMD_DATA = '0; CMD_ITER = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    VI_BUS = '0; SATISFY = 1'b0;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({WL_SW, WL_SIGN, BL_EN, BL_SI, BL_SL, BL_SR, SRAM_STATE, V, VUL_EN, VAR_STATE,
         V_PRE, STOCHASTIC_MODE, DONE, SOLVED, ITER_CNT} !== '0)
      begin tests_failed++; $display("FAIL reset_outputs: outputs not all zero during reset"); end
    tests_run++;
    if (CMD_READY !== 1'b1)
      begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", CMD_READY); end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write_directed();
    tests_run++;
    if (CMD_READY !== 1'b1)
      begin tests_failed++; $display("FAIL wr_ready_before: got %b expected 1", CMD_READY); end
    CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_WL = 6'd5; CMD_GRP = 3'd2;
    CMD_SIGN = 1'b1; CMD_DATA = 12'hA53;
    @(negedge CLK);
    drive_idle();
    #1;
    tests_run++;
    if (WL_SW !== (NVAR'(1) << 5))
      begin tests_failed++; $display("FAIL wr_wl_sw: got %h expected %h", WL_SW, NVAR'(1) << 5); end
    tests_run++;
    if (BL_EN !== 8'h04) begin tests_failed++; $display("FAIL wr_bl_en: got %h expected 04", BL_EN); end
    tests_run++;
    if (BL_SI !== 32'h300) begin tests_failed++; $display("FAIL wr_bl_si: got %h expected 300", BL_SI); end
    tests_run++;
    if (BL_SL !== 32'h500) begin tests_failed++; $display("FAIL wr_bl_sl: got %h expected 500", BL_SL); end
    tests_run++;
    if (BL_SR !== 32'hA00) begin tests_failed++; $display("FAIL wr_bl_sr: got %h expected a00", BL_SR); end
    tests_run++;
    if ({SRAM_STATE, WL_SIGN, CMD_READY} !== 3'b110)
      begin tests_failed++; $display("FAIL wr_ctrl: got %b expected 110", {SRAM_STATE, WL_SIGN, CMD_READY}); end
    @(negedge CLK);
    tests_run++;
    if ({SRAM_STATE, CMD_READY, |WL_SW, |BL_EN} !== 4'b0100)
      begin tests_failed++; $display("FAIL wr_after: got %b expected 0100", {SRAM_STATE, CMD_READY, |WL_SW, |BL_EN}); end
  endtask

  task automatic test_write_wl63();
    CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_WL = 6'd63; CMD_GRP = 3'd7;
    CMD_SIGN = 1'b0; CMD_DATA = 12'hFFF;
    @(negedge CLK);
    drive_idle();
    tests_run++;
    if ({WL_SW, SRAM_STATE, BL_EN} !== {{NVAR{1'b0}}, 1'b1, 8'h80})
      begin tests_failed++; $display("FAIL wr63_wl_sw: got wl %h sram %b bl_en %h expected 0 1 80", WL_SW, SRAM_STATE, BL_EN); end
    @(negedge CLK);
    tests_run++;
    if ({CMD_READY, SRAM_STATE} !== 2'b10)
      begin tests_failed++; $display("FAIL wr63_return: got %b expected 10", {CMD_READY, SRAM_STATE}); end
  endtask

  // CMD_VALID stays high for a run of random writes. Each write takes an
  // accept cycle and a write cycle. The command inputs are scrambled during
  // the write cycle, so only captured fields can produce the right outputs.
  task automatic test_back_to_back();
    logic [5:0]      wl;
    logic [2:0]      grp;
    logic            sgn;
    logic [11:0]     dat;
    logic [63:0]     wl64;
    logic [7:0]      en;
    logic [31:0]     si, sl, sr;
    logic [WR_W-1:0] obs, expv;
    for (int n = 0; n < 12; n++) begin
      wl  = 6'($urandom_range(0, 63));
      grp = 3'($urandom_range(0, 7));
      sgn = 1'($urandom_range(0, 1));
      dat = 12'($urandom);
      CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_WL = wl; CMD_GRP = grp;
      CMD_SIGN = sgn; CMD_DATA = dat;
      tests_run++;
      if ({CMD_READY, SRAM_STATE} !== 2'b10)
        begin tests_failed++; $display("FAIL b2b_accept_cycle: got %b expected 10", {CMD_READY, SRAM_STATE}); end
      wl64 = (int'(wl) < NVAR) ? (64'd1 << wl) : 64'd0;
      en   = 8'd1 << grp;
      si   = 32'(dat[3:0])  << (4 * grp);
      sl   = 32'(dat[7:4])  << (4 * grp);
      sr   = 32'(dat[11:8]) << (4 * grp);
      exp_q.push_back({wl64[NVAR-1:0], sgn, en, si, sl, sr});
      @(negedge CLK);
      CMD_WL = 6'($urandom); CMD_GRP = 3'($urandom); CMD_SIGN = 1'($urandom); CMD_DATA = 12'($urandom);
      #1;
      obs  = {WL_SW, WL_SIGN, BL_EN, BL_SI, BL_SL, BL_SR};
      expv = exp_q.pop_front();
      tests_run++;
      if (obs !== expv)
        begin tests_failed++; $display("FAIL b2b_write_%0d: got %h expected %h", n, obs, expv); end
      tests_run++;
      if ({CMD_READY, SRAM_STATE} !== 2'b01)
        begin tests_failed++; $display("FAIL b2b_write_cycle: got %b expected 01", {CMD_READY, SRAM_STATE}); end
      if (n == 11) drive_idle();
      @(negedge CLK);
    end
    tests_run++;
    if (exp_q.size() != 0)
      begin tests_failed++; $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size()); end
  endtask

  // One solve, checked every cycle against the command schedule.
  // satAt is the sweep whose check sees SATISFY=1; a value past the limit
  // means the solve never succeeds.
  task automatic run_solve(input string name, input int limit, input int satAt, input bit allOnes);
    int              effLimit, sweeps, endC, r, k;
    bit              isPulse, isCap, isChk;
    logic [NVAR-1:0] expVul, vi;
    logic [4:0]      expCtrl, obsCtrl;
    logic            expStoch;
    effLimit = (limit == 0) ? 1 : limit;
    if (satAt <= effLimit) begin sweeps = satAt;    expSolved = 1'b1; end
    else                   begin sweeps = effLimit; expSolved = 1'b0; end
    expIter = ITER_W'(sweeps);
    expV    = '0;
    endC    = 1 + sweeps * SWEEP + 1;
    tests_run++;
    if (CMD_READY !== 1'b1)
      begin tests_failed++; $display("FAIL %s_ready: got %b expected 1", name, CMD_READY); end
    CMD_VALID = 1'b1; CMD_OP = 2'd1; CMD_ITER = ITER_W'(limit);
    @(negedge CLK);
    drive_idle();
    for (int c = 1; c <= endC + 1; c++) begin
      isPulse = 1'b0; isCap = 1'b0; isChk = 1'b0; k = 0;
      expVul = '0;
      if (c == 1) expVul = '1;
      else if (c < endC) begin
        r = (c - 2) % SWEEP;
        if (r < 2 * NVAR) begin
          k = r / 2;
          if (r % 2 == 0) begin isPulse = 1'b1; expVul = NVAR'(1) << k; end
          else isCap = 1'b1;
        end else isChk = 1'b1;
      end
      tests_run++;
      if (VUL_EN !== expVul)
        begin tests_failed++; $display("FAIL %s_vul_en_c%0d: got %h expected %h", name, c, VUL_EN, expVul); end
      // {CMD_READY, DONE, VAR_STATE, SRAM_STATE, V_PRE}
      expCtrl = {c == endC + 1, c == endC, c == 1, 1'b0, 1'b0};
      obsCtrl = {CMD_READY, DONE, VAR_STATE, SRAM_STATE, V_PRE};
      tests_run++;
      if (obsCtrl !== expCtrl)
        begin tests_failed++; $display("FAIL %s_ctrl_c%0d: got %b expected %b", name, c, obsCtrl, expCtrl); end
`ifdef VPE_SEQ_STOCH_EN
      expStoch = isPulse && (lfsrModel[3:0] == 4'd0);
`else
      expStoch = 1'b0;
`endif
      tests_run++;
      if (STOCHASTIC_MODE !== expStoch)
        begin tests_failed++; $display("FAIL %s_stoch_c%0d: got %b expected %b", name, c, STOCHASTIC_MODE, expStoch); end
      if (c == 2) begin
        tests_run++;
        if (V !== '0) begin tests_failed++; $display("FAIL %s_seed_clear: got %h expected 0", name, V); end
      end
      vi = allOnes ? '1 : NVAR'({$urandom, $urandom});
      VI_BUS = vi;
      if (isCap) expV[k] = vi[k];
      SATISFY = isChk ? (((c - 2) / SWEEP + 1) == satAt) : 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    SATISFY = 1'b0;
    tests_run++;
    if (SOLVED !== expSolved)
      begin tests_failed++; $display("FAIL %s_solved: got %b expected %b", name, SOLVED, expSolved); end
    tests_run++;
    if (ITER_CNT !== expIter)
      begin tests_failed++; $display("FAIL %s_iter_cnt: got %0d expected %0d", name, ITER_CNT, expIter); end
    tests_run++;
    if (V !== expV)
      begin tests_failed++; $display("FAIL %s_v: got %h expected %h", name, V, expV); end
  endtask

  task automatic test_solve_sat();
    run_solve("solve_sat", 3, 1, 1'b1);
    tests_run++;
    if (V !== '1) begin tests_failed++; $display("FAIL solve_sat_all_ones: got %h expected all ones", V); end
  endtask

  task automatic test_solve_unsat();
    run_solve("solve_unsat", 3, 99, 1'b0);
  endtask

  task automatic test_solve_limit0();
    run_solve("solve_limit0", 0, 99, 1'b0);
  endtask

  task automatic test_solve_random();
    int lim, sat;
    for (int n = 0; n < 3; n++) begin
      lim = $urandom_range(1, 4);
      sat = $urandom_range(1, 5);
      run_solve($sformatf("solve_rnd%0d", n), lim, sat, 1'b0);
    end
  endtask

  // Reserved ops and writes must leave the last solve result untouched.
  task automatic test_reserved_hold();
    for (int op = 2; op <= 4; op++) begin
      CMD_VALID = 1'b1;
      CMD_OP = (op == 4) ? 2'd0 : 2'(op);
      CMD_WL = 6'($urandom); CMD_GRP = 3'($urandom); CMD_DATA = 12'($urandom);
      @(negedge CLK);
      drive_idle();
      if (op != 4) begin
        tests_run++;
        if ({CMD_READY, SRAM_STATE, VAR_STATE, |VUL_EN} !== 4'b1000)
          begin tests_failed++; $display("FAIL reserved_op%0d: got %b expected 1000", op, {CMD_READY, SRAM_STATE, VAR_STATE, |VUL_EN}); end
      end else @(negedge CLK);
      tests_run++;
      if ({SOLVED, ITER_CNT, V} !== {expSolved, expIter, expV})
        begin tests_failed++; $display("FAIL hold_op%0d: got %b %0d %h expected %b %0d %h", op, SOLVED, ITER_CNT, V, expSolved, expIter, expV); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    CMD_VALID = 1'b1; CMD_OP = 2'd1; CMD_ITER = ITER_W'(2);
    @(negedge CLK);
    drive_idle();
    // Cycle 1 is SEED; PULSE for variable 30 falls on cycle 2 + 2*30.
    for (int c = 1; c < 2 + 2 * 30; c++) begin
      VI_BUS = '1;
      SATISFY = 1'b0;
      @(negedge CLK);
    end
    tests_run++;
    if (VUL_EN !== (NVAR'(1) << 30))
      begin tests_failed++; $display("FAIL midrst_pulse30: got %h expected %h", VUL_EN, NVAR'(1) << 30); end
    RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({WL_SW, WL_SIGN, BL_EN, BL_SI, BL_SL, BL_SR, SRAM_STATE, V, VUL_EN, VAR_STATE,
         V_PRE, STOCHASTIC_MODE, DONE, SOLVED, ITER_CNT} !== '0)
      begin tests_failed++; $display("FAIL midrst_outputs: V %h VUL_EN %h ITER_CNT %0d not all zero", V, VUL_EN, ITER_CNT); end
    tests_run++;
    if (CMD_READY !== 1'b1)
      begin tests_failed++; $display("FAIL midrst_ready: got %b expected 1", CMD_READY); end
    VI_BUS = '0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    run_solve("after_rst", 2, 2, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_directed();
    test_write_wl63();
    test_back_to_back();
    test_solve_sat();
    test_solve_unsat();
    test_solve_limit0();
    test_reserved_hold();
    test_solve_random();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
